// File: rtl/sr_reg_bank.sv
// sr_reg_bank: bank of WIDTH independent SR (or JK) storage channels with sticky per-channel
// invalid-input flags and a saturating count of cycles containing at least one invalid input.
//
// Parameters
//   WIDTH      number of channels (1..32)
//   MODE       0: SR behaviour, 1: JK behaviour (S=R=1 toggles, never invalid)
//   INV_POLICY SR-mode S=R=1 resolution: 0 hold, 1 set, 2 reset, 3 force Q=0 and Qbar=0
//   CNT_W      width of the invalid-cycle counter
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   en       update enable; all state holds while low (err_clr included)
//   S, R     per-channel set / reset requests
//   err_clr  clears err and inv_cnt (a same-edge invalid event is still recorded)
//   Q        per-channel registered state
//   Qbar     ~Q, except 0 on channels held in the forced-low state
//   err      per-channel sticky invalid flag
//   inv_cnt  saturating count of enabled edges with at least one invalid channel
module sr_reg_bank #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MODE       = 0,
  parameter int unsigned INV_POLICY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             err_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] inv_cnt
);

  localparam bit JkMode = (MODE == 1);

  logic [WIDTH-1:0] q_q, q_d;
  // Channels currently in the INV_POLICY=3 state where both Q and Qbar are low.
  logic [WIDTH-1:0] forced_q, forced_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] inv_vec;
  logic             any_inv;

  always_comb begin
    q_d      = q_q;
    forced_d = forced_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    inv_vec  = '0;
    any_inv  = 1'b0;

    if (en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        unique case ({S[i], R[i]})
          2'b10: begin
            q_d[i]      = 1'b1;
            forced_d[i] = 1'b0;
          end
          2'b01: begin
            q_d[i]      = 1'b0;
            forced_d[i] = 1'b0;
          end
          2'b11: begin
            if (JkMode) begin
              q_d[i]      = ~q_q[i];
              forced_d[i] = 1'b0;
            end else begin
              inv_vec[i] = 1'b1;
              unique case (INV_POLICY)
                1: begin
                  q_d[i]      = 1'b1;
                  forced_d[i] = 1'b0;
                end
                2: begin
                  q_d[i]      = 1'b0;
                  forced_d[i] = 1'b0;
                end
                3: begin
                  q_d[i]      = 1'b0;
                  forced_d[i] = 1'b1;
                end
                default: ; // hold, including any existing forced state
              endcase
            end
          end
          default: ; // S=R=0 holds, forced state included
        endcase
      end

      any_inv = |inv_vec;

      if (err_clr) begin
        // Clear wins over history but not over an invalid event on this same edge.
        err_d = inv_vec;
        cnt_d = any_inv ? CNT_W'(1) : '0;
      end else begin
        err_d = err_q | inv_vec;
        if (any_inv && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q      <= '0;
      forced_q <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      q_q      <= q_d;
      forced_q <= forced_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign Qbar    = ~q_q & ~forced_q;
  assign err     = err_q;
  assign inv_cnt = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] S;
  logic [3:0] R;
  logic       err_clr;

  // p0..p3: MODE=0 with INV_POLICY 0..3; jk: MODE=1; c2: MODE=0, policy 0, CNT_W=2.
  logic [3:0] q_p0, qb_p0, e_p0; logic [7:0] c_p0;
  logic [3:0] q_p1, qb_p1, e_p1; logic [7:0] c_p1;
  logic [3:0] q_p2, qb_p2, e_p2; logic [7:0] c_p2;
  logic [3:0] q_p3, qb_p3, e_p3; logic [7:0] c_p3;
  logic [3:0] q_jk, qb_jk, e_jk; logic [7:0] c_jk;
  logic [3:0] q_c2, qb_c2, e_c2; logic [1:0] c_c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_reg_bank #(.WIDTH(4), .MODE(0), .INV_POLICY(0), .CNT_W(8)) u_p0 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(q_p0), .Qbar(qb_p0), .err(e_p0), .inv_cnt(c_p0));
  sr_reg_bank #(.WIDTH(4), .MODE(0), .INV_POLICY(1), .CNT_W(8)) u_p1 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(q_p1), .Qbar(qb_p1), .err(e_p1), .inv_cnt(c_p1));
  sr_reg_bank #(.WIDTH(4), .MODE(0), .INV_POLICY(2), .CNT_W(8)) u_p2 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(q_p2), .Qbar(qb_p2), .err(e_p2), .inv_cnt(c_p2));
  sr_reg_bank #(.WIDTH(4), .MODE(0), .INV_POLICY(3), .CNT_W(8)) u_p3 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(q_p3), .Qbar(qb_p3), .err(e_p3), .inv_cnt(c_p3));
  sr_reg_bank #(.WIDTH(4), .MODE(1), .INV_POLICY(0), .CNT_W(8)) u_jk (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(q_jk), .Qbar(qb_jk), .err(e_jk), .inv_cnt(c_jk));
  sr_reg_bank #(.WIDTH(4), .MODE(0), .INV_POLICY(0), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(q_c2), .Qbar(qb_c2), .err(e_c2), .inv_cnt(c_c2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst_v, input logic en_v, input logic [3:0] s_v,
                       input logic [3:0] r_v, input logic clr_v);
    reset   = rst_v;
    en      = en_v;
    S       = s_v;
    R       = r_v;
    err_clr = clr_v;
  endtask

  initial begin
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);

    // Reset held for two edges.
    tick(); tick();
    check("rst_q",    q_p0,  4'b0000);
    check("rst_qbar", qb_p0, 4'b1111);
    check("rst_err",  e_p0,  4'b0000);
    check("rst_cnt",  c_p0,  8'd0);
    check("rst_qbar_p3", qb_p3, 4'b1111);

    // Basic set after release.
    drive(1'b1, 1'b1, 4'b0101, 4'b0000, 1'b0);
    tick();
    check("set_q",    q_p0,  4'b0101);
    check("set_qbar", qb_p0, 4'b1010);

    // Establish Q=0011.
    drive(1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0);
    tick();
    check("sr_q", q_p0, 4'b0011);

    // Invalid on channel 0 under each policy.
    drive(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
    tick();
    check("p0_q",    q_p0,  4'b0011);
    check("p0_err",  e_p0,  4'b0001);
    check("p0_cnt",  c_p0,  8'd1);
    check("p1_q",    q_p1,  4'b0011);
    check("p2_q",    q_p2,  4'b0010);
    check("p2_qbar", qb_p2, 4'b1101);
    check("p3_q",    q_p3,  4'b0010);
    check("p3_qbar", qb_p3, 4'b1100);
    check("p3_err",  e_p3,  4'b0001);
    check("jk_q",    q_jk,  4'b0010);
    check("jk_err",  e_jk,  4'b0000);
    check("jk_cnt",  c_jk,  8'd0);

    // Hold keeps the forced state; a set releases it.
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("p3_hold_q",    q_p3,  4'b0010);
    check("p3_hold_qbar", qb_p3, 4'b1100);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
    tick();
    check("p3_set_q",    q_p3,  4'b0011);
    check("p3_set_qbar", qb_p3, 4'b1100);
    check("p3_err_sticky", e_p3, 4'b0001);

    // Fresh start, then S=R=1111 for five edges.
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("rst2_jk_q", q_jk, 4'b0000);
    drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
    tick();
    check("jk_t1", q_jk, 4'b1111);
    check("c2_1",  c_c2, 2'd1);
    tick();
    check("jk_t2", q_jk, 4'b0000);
    check("c2_2",  c_c2, 2'd2);
    tick();
    check("jk_t3", q_jk, 4'b1111);
    check("jk_err3", e_jk, 4'b0000);
    check("jk_cnt3", c_jk, 8'd0);
    check("c2_3",  c_c2, 2'd3);
    tick();
    check("c2_4",  c_c2, 2'd3);
    tick();
    check("c2_5",  c_c2, 2'd3);
    check("p0_cnt5", c_p0, 8'd5);
    check("p0_err5", e_p0, 4'b1111);

    // Clear together with a new invalid on channel 2.
    drive(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1);
    tick();
    check("c2_clr_err", e_c2, 4'b0100);
    check("c2_clr_cnt", c_c2, 2'd1);
    check("p0_clr_cnt", c_p0, 8'd1);
    check("jk_ch2", q_jk, 4'b1011);

    // Disabled: invalid inputs and clear are ignored.
    drive(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1);
    tick(); tick(); tick();
    check("dis_q",   q_p0, 4'b0000);
    check("dis_err", e_p0, 4'b0100);
    check("dis_cnt", c_p0, 8'd1);
    check("dis_jk",  q_jk, 4'b1011);

    // Clear with no invalid event.
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    tick();
    check("clr_err", e_p0, 4'b0000);
    check("clr_cnt", c_p0, 8'd0);

    // Build Q=1111, err=1000, inv_cnt=5, then reset.
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("pre_q",   q_p0,  4'b1111);
    check("pre_err", e_p0,  4'b1000);
    check("pre_cnt", c_p0,  8'd5);
    check("pre_p3_qbar", qb_p3, 4'b0000);
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
    tick();
    check("mid_q",    q_p0,  4'b0000);
    check("mid_qbar", qb_p0, 4'b1111);
    check("mid_err",  e_p0,  4'b0000);
    check("mid_cnt",  c_p0,  8'd0);
    check("mid_p3_qbar", qb_p3, 4'b1111);
    check("mid_c2_cnt",  c_c2, 2'd0);

    // First update after release.
    drive(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0);
    tick();
    check("post_q", q_p0, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_reg_bank.md
SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent SR channels (1..32).
REQ-002 Parameter MODE, default 0: 0 = SR behaviour, 1 = JK behaviour (S=R=1 toggles).
REQ-003 Parameter INV_POLICY, default 0: SR-mode S=R=1 resolution; 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = force Q=0 and Qbar=0 (both low).
REQ-004 Parameter CNT_W, default 8: width of the invalid-event counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-007 en  input  1  update enable; when 0, all channel state holds.
REQ-008 S  input  WIDTH  per-channel set request.
REQ-009 R  input  WIDTH  per-channel reset request.
REQ-010 err_clr  input  1  clears the sticky error flags and the counter.
REQ-011 Q  output  WIDTH  per-channel registered state.
REQ-012 Qbar  output  WIDTH  per-channel complement output.
REQ-013 err  output  WIDTH  per-channel sticky flag: an invalid S=R=1 was accepted.
REQ-014 inv_cnt  output  CNT_W  count of cycles in which at least one channel was invalid.

Function
REQ-015 Channel i SHALL update only on a rising clk edge with reset=1 and en=1; one-cycle latency from S/R to Q.
REQ-016 S=0,R=0 SHALL hold Q[i]; S=1,R=0 SHALL set Q[i]=1; S=0,R=1 SHALL set Q[i]=0.
REQ-017 MODE=1, S=R=1: Q[i] SHALL toggle; this is not an invalid event.
REQ-018 MODE=0, S=R=1: Q[i] SHALL follow INV_POLICY; this is an invalid event for channel i.
REQ-019 Qbar[i] SHALL equal ~Q[i], except when channel i is in the INV_POLICY=3 forced state, where Qbar[i]=0.
REQ-020 The INV_POLICY=3 forced state SHALL persist until the next valid set, reset or hold-free update on that channel; a hold (S=R=0) SHALL keep it.
REQ-021 An invalid event on channel i SHALL set err[i]=1 on the same edge; err[i] stays set until err_clr or reset.
REQ-022 inv_cnt SHALL increment by 1 on each enabled edge with at least one invalid channel, regardless of how many channels are invalid, and saturate at 2^CNT_W-1.
REQ-023 en=0: no Q, err or inv_cnt update; S/R are ignored, including S=R=1.
REQ-024 err_clr=1 with no invalid event on that edge: err and inv_cnt SHALL clear to 0.
REQ-025 err_clr=1 together with an invalid event: err SHALL equal exactly the newly-invalid channel bits, and inv_cnt SHALL equal 1.
REQ-026 err_clr SHALL act only while en=1; with en=0 it is ignored.
REQ-027 Channels SHALL be fully independent; activity on one channel never affects another channel's Q.

Reset
REQ-028 reset=0 at a rising edge SHALL force Q=0, Qbar=all ones, err=0 and inv_cnt=0, overriding en, S, R and err_clr.
REQ-029 Reset asserted mid-operation, including in the forced or saturated states, SHALL fully clear all state in one cycle; the first update after release occurs on the next edge with reset=1.
REQ-030 Outputs SHALL not change between clock edges except when driven combinationally from registered state.

Verification (WIDTH=4, CNT_W=8 unless stated)
REQ-031 Reset held for 2 edges, then released; then S=4'b0101, R=0 -> Q=4'b0101, Qbar=4'b1010 one cycle after.
REQ-032 MODE=0, INV_POLICY=0: Q=4'b0011, S=R=4'b0001 -> Q=4'b0011, err=4'b0001, inv_cnt=1; repeat under INV_POLICY 1/2/3 -> Q[0]=1/0/0, and for policy 3 Qbar[0]=0.
REQ-033 MODE=1: Q=4'b0000, S=R=4'b1111 for 3 edges -> Q toggles 1111, 0000, 1111; err=0, inv_cnt=0.
REQ-034 CNT_W=2: invalid on every edge for 5 edges -> inv_cnt = 1, 2, 3, 3, 3; then err_clr=1 with an invalid on channel 2 -> err=4'b0100, inv_cnt=1.
REQ-035 en=0 with S=R=4'b1111 and err_clr=1 for 3 edges -> Q, err and inv_cnt unchanged.
REQ-036 Reset asserted with Q=4'b1111, err=4'b1000 and inv_cnt=5 -> next edge Q=0, Qbar=4'b1111, err=0, inv_cnt=0.
